// File: rtl/gray_count_sequencer.sv
// Gray up/down count sequencer.
// Two requesters issue "step N times up/down" commands over valid/ready.
// A round-robin arbiter grants one command at a time, and an FSM steps an
// internal binary counter whose Gray-coded value drives cg_o.
module gray_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_vld_i,
    input  logic             a_dir_i,
    input  logic [CNT_W-1:0] a_cnt_i,
    output logic             a_rdy_o,
    input  logic             b_vld_i,
    input  logic             b_dir_i,
    input  logic [CNT_W-1:0] b_cnt_i,
    output logic             b_rdy_o,
    input  logic             en_i,
    output logic [WIDTH-1:0] cg_o,
    output logic             owner_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;

    logic               isIdle;
    logic               grantA;
    logic               grantB;
    logic               accept;
    logic               selDir;
    logic [CNT_W-1:0]   selCnt;

    // Round-robin arbitration: on a tie the requester that was not served last wins.
    always_comb begin
        isIdle  = (state_q == S_IDLE);
        grantA  = a_vld_i & (~b_vld_i | last_q);
        grantB  = b_vld_i & (~a_vld_i | ~last_q);
        a_rdy_o = isIdle & grantA;
        b_rdy_o = isIdle & grantB;
        accept  = a_rdy_o | b_rdy_o;
        selDir  = b_rdy_o ? b_dir_i : a_dir_i;
        selCnt  = b_rdy_o ? b_cnt_i : a_cnt_i;
    end

    // Next-state logic: latch a command in IDLE, step the counter in RUN, pulse in DONE.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d   = selDir;
                    owner_d = b_rdy_o;
                    last_d  = b_rdy_o;
                    rem_d   = selCnt;
                    state_d = (selCnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (en_i) begin
                    bin_d = dir_q ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any command in flight and favours A on the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode directly from registered state so the Gray value has no extra latency.
    always_comb begin
        cg_o    = bin_q ^ (bin_q >> 1);
        owner_o = owner_q;
        busy_o  = (state_q != S_IDLE);
        done_o  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Testbench for gray_count_sequencer: directed commands with a queue of expected Gray values.
module tb_gray_count_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             a_vld_i;
    logic             a_dir_i;
    logic [CNT_W-1:0] a_cnt_i;
    logic             a_rdy_o;
    logic             b_vld_i;
    logic             b_dir_i;
    logic [CNT_W-1:0] b_cnt_i;
    logic             b_rdy_o;
    logic             en_i;
    logic [WIDTH-1:0] cg_o;
    logic             owner_o;
    logic             busy_o;
    logic             done_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int modelBin   = 0;
    logic [WIDTH-1:0] expQ[$];

    gray_count_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_vld_i (a_vld_i),
        .a_dir_i (a_dir_i),
        .a_cnt_i (a_cnt_i),
        .a_rdy_o (a_rdy_o),
        .b_vld_i (b_vld_i),
        .b_dir_i (b_dir_i),
        .b_cnt_i (b_cnt_i),
        .b_rdy_o (b_rdy_o),
        .en_i    (en_i),
        .cg_o    (cg_o),
        .owner_o (owner_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH-1:0] toGray(input int b);
        logic [WIDTH-1:0] v;
        v = b[WIDTH-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset;
        rst_i   = 1'b1;
        a_vld_i = 1'b0;
        a_dir_i = 1'b0;
        a_cnt_i = '0;
        b_vld_i = 1'b0;
        b_dir_i = 1'b0;
        b_cnt_i = '0;
        en_i    = 1'b1;
        tick;
        tick;
        rst_i = 1'b0;
        modelBin = 0;
        expQ.delete();
        checkOutput("rst_cg",    32'(cg_o),    32'd0);
        checkOutput("rst_busy",  32'(busy_o),  32'd0);
        checkOutput("rst_done",  32'(done_o),  32'd0);
        checkOutput("rst_owner", 32'(owner_o), 32'd0);
    endtask

    // Issue one command, push its expected Gray sequence, then compare every step.
    // pauseAt < 0 means EN stays high; otherwise EN drops for pauseLen cycles after pauseAt steps.
    task automatic applyStimulus(input bit isB, input bit dir, input int cnt,
                                 input int pauseAt, input int pauseLen);
        logic [WIDTH-1:0] prevCg;
        logic [WIDTH-1:0] expCg;
        int waited;
        int step;
        if (isB) begin
            b_vld_i = 1'b1;
            b_dir_i = dir;
            b_cnt_i = cnt[CNT_W-1:0];
        end else begin
            a_vld_i = 1'b1;
            a_dir_i = dir;
            a_cnt_i = cnt[CNT_W-1:0];
        end
        #1;
        waited = 0;
        while (!(isB ? b_rdy_o : a_rdy_o) && waited < 20) begin
            tick;
            waited++;
        end
        if (waited >= 20) begin
            checkOutput("rdy_timeout", 32'd0, 32'd1);
            if (isB) b_vld_i = 1'b0; else a_vld_i = 1'b0;
            return;
        end
        checkOutput("rdy_other", 32'(isB ? a_rdy_o : b_rdy_o), 32'd0);
        prevCg = cg_o;
        for (int i = 0; i < cnt; i++) begin
            modelBin = dir ? (modelBin + 1) % (1 << WIDTH)
                           : (modelBin + (1 << WIDTH) - 1) % (1 << WIDTH);
            expQ.push_back(toGray(modelBin));
        end
        tick;
        if (isB) b_vld_i = 1'b0; else a_vld_i = 1'b0;
        checkOutput("busy_accept", 32'(busy_o), 32'd1);
        checkOutput("owner_accept", 32'(owner_o), 32'(isB));
        checkOutput("rdy_busy", 32'(a_rdy_o | b_rdy_o), 32'd0);
        if (cnt == 0) begin
            checkOutput("zero_done", 32'(done_o), 32'd1);
            checkOutput("zero_cg", 32'(cg_o), 32'(prevCg));
        end else begin
            step = 0;
            while (expQ.size() > 0) begin
                if (step == pauseAt && pauseLen > 0) begin
                    en_i = 1'b0;
                    repeat (pauseLen) begin
                        tick;
                        checkOutput("pause_cg", 32'(cg_o), 32'(prevCg));
                        checkOutput("pause_done", 32'(done_o), 32'd0);
                    end
                    en_i = 1'b1;
                end
                tick;
                expCg = expQ.pop_front();
                checkOutput("step_cg", 32'(cg_o), 32'(expCg));
                checkOutput("one_bit", 32'($countones(cg_o ^ prevCg)), 32'd1);
                checkOutput("step_done", 32'(done_o), 32'(expQ.size() == 0));
                prevCg = cg_o;
                step++;
            end
        end
        tick;
        checkOutput("idle_done", 32'(done_o), 32'd0);
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
        checkOutput("idle_owner", 32'(owner_o), 32'(isB));
    endtask

    // Directed sequence of scenarios.
    initial begin
        // T1: A up 5 from reset.
        $display("[TB] T1 single up command");
        doReset;
        applyStimulus(1'b0, 1'b1, 5, -1, 0);
        checkOutput("t1_final_cg", 32'(cg_o), 32'b0111);

        // T2: both valid from reset, A wins the first tie, B follows; then ties alternate.
        $display("[TB] T2 arbitration");
        doReset;
        b_vld_i = 1'b1;
        b_dir_i = 1'b0;
        b_cnt_i = 4'd1;
        applyStimulus(1'b0, 1'b1, 2, -1, 0);
        checkOutput("t2_a_cg", 32'(cg_o), 32'b0011);
        applyStimulus(1'b1, 1'b0, 1, -1, 0);
        checkOutput("t2_b_cg", 32'(cg_o), 32'b0001);
        b_vld_i = 1'b1;
        b_cnt_i = 4'd0;
        applyStimulus(1'b0, 1'b1, 0, -1, 0);
        a_vld_i = 1'b1;
        a_cnt_i = 4'd0;
        applyStimulus(1'b1, 1'b1, 0, -1, 0);
        a_vld_i = 1'b0;

        // T3: wrap in both directions.
        $display("[TB] T3 wrap-around");
        doReset;
        applyStimulus(1'b0, 1'b0, 1, -1, 0);
        checkOutput("t3_down_wrap", 32'(cg_o), 32'b1000);
        applyStimulus(1'b1, 1'b1, 1, -1, 0);
        checkOutput("t3_up_wrap", 32'(cg_o), 32'b0000);
        applyStimulus(1'b0, 1'b0, 1, -1, 0);
        checkOutput("t3_down_again", 32'(cg_o), 32'b1000);

        // T4: pause mid-run for two cycles.
        $display("[TB] T4 enable pause");
        doReset;
        applyStimulus(1'b0, 1'b1, 3, 1, 2);
        checkOutput("t4_final_cg", 32'(cg_o), 32'b0010);

        // T5: zero-step command leaves the count untouched.
        $display("[TB] T5 zero-step command");
        applyStimulus(1'b1, 1'b0, 0, -1, 0);
        checkOutput("t5_cg", 32'(cg_o), 32'b0010);

        // T6: reset after two of six steps.
        $display("[TB] T6 reset mid-run");
        doReset;
        a_vld_i = 1'b1;
        a_dir_i = 1'b1;
        a_cnt_i = 4'd6;
        #1;
        checkOutput("t6_rdy", 32'(a_rdy_o), 32'd1);
        tick;
        a_vld_i = 1'b0;
        tick;
        tick;
        checkOutput("t6_mid_cg", 32'(cg_o), 32'b0011);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        checkOutput("t6_rst_cg",   32'(cg_o),   32'd0);
        checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("t6_rst_done", 32'(done_o), 32'd0);
        b_vld_i = 1'b1;
        #1;
        checkOutput("t6_b_rdy", 32'(b_rdy_o), 32'd1);
        b_vld_i = 1'b0;
        modelBin = 0;
        expQ.delete();
        applyStimulus(1'b0, 1'b1, 2, -1, 0);
        checkOutput("t6_new_cg", 32'(cg_o), 32'b0011);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
